// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply or restoring divide over WORD_SIZE
// iterations, then one sign-fix cycle; fixed latency for every operation and operand value.
module mul_div_unit #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Start,
  input  logic                 i_Kill,
  input  logic [2:0]           i_Funct3,
  input  logic [WORD_SIZE-1:0] i_Op1,
  input  logic [WORD_SIZE-1:0] i_Op2,
  output logic [WORD_SIZE-1:0] o_Result,
  output logic                 o_Busy,
  output logic                 o_Done
);
  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            accept;

  logic [2:0]      funct_q;
  logic            n1_q, n2_q, div0_q;
  logic [W-1:0]    op1_q, opb_q, res_q;
  logic [2*W-1:0]  acc_q;

  logic            s1_signed, s2_signed, n1, n2;
  logic [W-1:0]    abs1, abs2;
  logic [W:0]      mul_sum, div_shift, div_trial;
  logic [2*W-1:0]  mul_next, div_next;

  // Sign fixes applied to the unsigned magnitude result; divide-by-zero overrides them.
  function automatic logic [W-1:0] fix_result(input logic [2:0] f, input logic [2*W-1:0] acc,
                                              input logic neg, input logic rneg,
                                              input logic div0, input logic [W-1:0] op1);
    logic [2*W-1:0] p;
    logic [W-1:0]   q, r;
    p = neg  ? -acc : acc;
    q = neg  ? -acc[W-1:0] : acc[W-1:0];
    r = rneg ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (f)
      3'b000:                 fix_result = p[W-1:0];
      3'b001, 3'b010, 3'b011: fix_result = p[2*W-1:W];
      3'b100, 3'b101:         fix_result = div0 ? {W{1'b1}} : q;
      default:                fix_result = div0 ? op1 : r;
    endcase
  endfunction

  assign accept = ((state == IDLE) || (state == DONE)) && i_Start && !i_Kill;

  always_comb begin
    s1_signed = (i_Funct3 == 3'b001) || (i_Funct3 == 3'b010) ||
                (i_Funct3 == 3'b100) || (i_Funct3 == 3'b110);
    s2_signed = (i_Funct3 == 3'b001) || (i_Funct3 == 3'b100) || (i_Funct3 == 3'b110);
    n1   = s1_signed & i_Op1[W-1];
    n2   = s2_signed & i_Op2[W-1];
    abs1 = n1 ? -i_Op1 : i_Op1;
    abs2 = n2 ? -i_Op2 : i_Op2;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_next  = div_trial[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
  end

  always_ff @(posedge i_Clk) begin
    if (accept) begin
      funct_q <= i_Funct3;
      n1_q    <= n1;
      n2_q    <= n2;
      op1_q   <= i_Op1;
      div0_q  <= (i_Op2 == {W{1'b0}});
      if (i_Funct3[2]) begin
        acc_q <= {{W{1'b0}}, abs1};
        opb_q <= abs2;
      end else begin
        acc_q <= {{W{1'b0}}, abs2};
        opb_q <= abs1;
      end
    end else if (state == CALC) begin
      acc_q <= funct_q[2] ? div_next : mul_next;
    end else if (state == FIX) begin
      res_q <= fix_result(funct_q, acc_q, n1_q ^ n2_q, n1_q, div0_q, op1_q);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
      o_Result <= '0;
    end else if (i_Kill) begin
      state  <= IDLE;
      o_Busy <= 1'b0;
      o_Done <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= CALC;
            cnt    <= '0;
            o_Busy <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          o_Busy <= 1'b0;
        end
        DONE: begin
          o_Done   <= 1'b1;
          o_Result <= res_q;
          if (accept) begin
            state  <= CALC;
            cnt    <= '0;
            o_Busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes model results, a monitor pops on o_Done.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct;
  logic [31:0] op1, op2, result;
  logic        busy, done;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  mul_div_unit #(.WORD_SIZE(32)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Kill(kill), .i_Funct3(funct),
    .i_Op1(op1), .i_Op2(op2), .o_Result(result), .o_Busy(busy), .o_Done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    int          ia, ib;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request, value and cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got result %h at cycle %0d, expected no done", result, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_result", result, e.res);
        check("sb_latency", cyc, e.at);
      end
    end
  end

  // Called just after a rising edge; the start is sampled on the next edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int acc_cyc);
    exp_t e;
    start = 1'b1;
    funct = f;
    op1   = a;
    op2   = b;
    acc_cyc = cyc + 1;
    if (!busy && !kill) begin
      e.res = ref_model(f, a, b);
      e.at  = acc_cyc + 34;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    funct = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 100);
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    int acc, bcnt, dcyc;
    wait_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(f, a, b, acc);
    bcnt = 0;
    dcyc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    check(name, result, exp);
    check({name, "_latency"}, dcyc - acc, 32'd34);
    check({name, "_busy_cycles"}, bcnt, 32'd33);
  endtask

  int          acc, ndone;
  logic [31:0] prev, a, b;
  logic [2:0]  f;

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct = '0; op1 = '0; op2 = '0;
    #1;
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_check("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_check("mulh", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    run_check("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_check("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_check("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_check("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_check("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_check("remu", 3'd7, 32'd100, 32'd7, 32'd2);
    run_check("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_check("divu_by0", 3'd5, 32'd9, 32'd0, 32'hFFFFFFFF);
    run_check("rem_by0", 3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB);
    run_check("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_check("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    // Kill ten cycles into an operation, then restart right away.
    wait_idle();
    @(posedge clk); #1;
    prev = result;
    issue(3'd5, 32'd1000, 32'd3, acc);
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    sbq.delete();
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_result", result, prev);
    @(posedge clk); #1;
    issue(3'd7, 32'd1000, 32'd7, acc);
    ndone = 0;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("kill_restart_dones", ndone, 32'd1);

    // Kill and start together: start is dropped.
    wait_idle();
    prev = result;
    start = 1'b1; kill = 1'b1; funct = 3'd0; op1 = 32'd3; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("kill_start_result", result, prev);

    // Back-to-back: second start lands in the DONE cycle.
    wait_idle();
    issue(3'd0, 32'd12345, 32'd678, acc);
    wait_idle();
    issue(3'd4, 32'hFFFF0000, 32'd17, acc);

    // Start mid-CALC is ignored; the first operation's result must come out.
    wait_idle();
    issue(3'd6, 32'd1000001, 32'd13, acc);
    repeat (5) begin @(posedge clk); #1; end
    issue(3'd0, 32'd99, 32'd99, acc);

    // Reset pulse mid-CALC.
    wait_idle();
    issue(3'd1, 32'hDEADBEEF, 32'h12345678, acc);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Randomized operations, issued back-to-back, biased toward corner operands.
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      f = 3'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        3: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(0, 20);
        default: b = $urandom;
      endcase
      issue(f, a, b, acc);
    end

    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
